// File: rtl/snoop_bus_ctrl.sv
// N-core snooping coherence bus controller: round-robin miss arbitration, snoop broadcast,
// write-back / fill / invalidate sequencing. Optional macro C2C_XFER_EN enables cache-to-cache transfer.
module snoop_bus_ctrl #(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CPU-1:0]        read_miss,
  input  logic [NUM_CPU-1:0]        write_miss,
  input  logic [NUM_CPU*ADDR_W-1:0] bico,
  input  logic [NUM_CPU-1:0]        search_found,
  input  logic [2*NUM_CPU-1:0]      snoop_state,
  input  logic                      mem_rdy,
  output logic [NUM_CPU-1:0]        grant,
  output logic [ADDR_W-1:0]         boci,
  output logic [NUM_CPU-1:0]        search,
  output logic [NUM_CPU-1:0]        wback,
  output logic [NUM_CPU-1:0]        invalidate,
  output logic [NUM_CPU-1:0]        datasel,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic                      busy
);
  localparam int PTR_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_EVAL, S_WB, S_FILL, S_INVAL, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                is_wr_q, is_wr_d;
  logic [NUM_CPU-1:0]  shr_q, shr_d;
  logic [ADDR_W-1:0]   boci_q, boci_d;
  logic [NUM_CPU-1:0]  grant_q, grant_d;
  logic [NUM_CPU-1:0]  search_q, search_d;
  logic [NUM_CPU-1:0]  wback_q, wback_d;
  logic [NUM_CPU-1:0]  inv_q, inv_d;
  logic [NUM_CPU-1:0]  datasel_q, datasel_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;

  logic [NUM_CPU-1:0]  cand;
  logic                arb_hit;
  logic [PTR_W-1:0]    arb_idx;
  logic [PTR_W-1:0]    idx_w;
  logic                own_hit;
  logic [PTR_W-1:0]    own_idx;
  logic [NUM_CPU-1:0]  shr_now;
  logic [1:0]          st;
  logic [NUM_CPU-1:0]  win_oh;

  function automatic logic [NUM_CPU-1:0] onehot(input logic [PTR_W-1:0] i);
    logic [NUM_CPU-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Round-robin: scan from the slot after the last winner, wrapping.
  always_comb begin
    cand    = read_miss | write_miss;
    arb_hit = 1'b0;
    arb_idx = '0;
    idx_w   = '0;
    for (int k = 1; k <= NUM_CPU; k++) begin
      idx_w = PTR_W'((int'(ptr_q) + k) % NUM_CPU);
      if (!arb_hit && cand[idx_w]) begin
        arb_hit = 1'b1;
        arb_idx = idx_w;
      end
    end
  end

  // Snoop responses from peers only; state 11 counts as invalid.
  always_comb begin
    own_hit = 1'b0;
    own_idx = '0;
    shr_now = '0;
    st      = 2'b00;
    for (int i = 0; i < NUM_CPU; i++) begin
      st = snoop_state[2*i +: 2];
      if (search_found[i] && (i != int'(win_q))) begin
        if (st == 2'b01 || st == 2'b10) shr_now[i] = 1'b1;
        if (st == 2'b10 && !own_hit) begin
          own_hit = 1'b1;
          own_idx = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    owner_d = owner_q;
    is_wr_d = is_wr_q;
    shr_d   = shr_q;
    boci_d  = boci_q;
    case (state_q)
      S_IDLE: if (arb_hit) begin
        state_d = S_GRANT;
        win_d   = arb_idx;
        is_wr_d = write_miss[arb_idx];
        boci_d  = bico[int'(arb_idx)*ADDR_W +: ADDR_W];
      end
      S_GRANT: state_d = S_EVAL;
      S_EVAL: begin
        owner_d = own_idx;
        shr_d   = shr_now;
        if (own_hit)      state_d = S_WB;
        else if (is_wr_q) state_d = S_INVAL;
        else              state_d = S_FILL;
      end
      S_WB: if (mem_rdy) begin
`ifdef C2C_XFER_EN
        state_d = is_wr_q ? S_INVAL : S_DONE;
`else
        state_d = is_wr_q ? S_INVAL : S_FILL;
`endif
      end
      S_FILL:  if (mem_rdy) state_d = S_DONE;
      S_INVAL: state_d = S_DONE;
      S_DONE: begin
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    win_oh    = onehot(win_d);
    grant_d   = '0;
    search_d  = '0;
    wback_d   = '0;
    inv_d     = '0;
    datasel_d = '0;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    busy_d    = (state_d != S_IDLE);
    if (state_d inside {S_GRANT, S_EVAL, S_WB, S_FILL, S_INVAL}) grant_d = win_oh;
    case (state_d)
      S_GRANT: search_d = ~win_oh;
      S_WB: begin
        wback_d  = onehot(owner_d);
        mem_we_d = 1'b1;
`ifdef C2C_XFER_EN
        if (!is_wr_d) datasel_d = win_oh;
`endif
      end
      S_FILL: begin
        mem_re_d  = 1'b1;
        datasel_d = win_oh;
      end
      S_INVAL: inv_d = shr_d & ~win_oh;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_W'(NUM_CPU - 1);
      win_q     <= '0;
      owner_q   <= '0;
      is_wr_q   <= 1'b0;
      shr_q     <= '0;
      boci_q    <= '0;
      grant_q   <= '0;
      search_q  <= '0;
      wback_q   <= '0;
      inv_q     <= '0;
      datasel_q <= '0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      owner_q   <= owner_d;
      is_wr_q   <= is_wr_d;
      shr_q     <= shr_d;
      boci_q    <= boci_d;
      grant_q   <= grant_d;
      search_q  <= search_d;
      wback_q   <= wback_d;
      inv_q     <= inv_d;
      datasel_q <= datasel_d;
      mem_re_q  <= mem_re_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign boci       = boci_q;
  assign search     = search_q;
  assign wback      = wback_q;
  assign invalidate = inv_q;
  assign datasel    = datasel_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Bench for snoop_bus_ctrl: directed scenarios plus randomized transactions against a
// transaction-level reference model (round-robin pick, snoop classification, phase sequence).
module tb_snoop_bus_ctrl;
  localparam int N  = 4;
  localparam int AW = 11;
`ifdef C2C_XFER_EN
  localparam bit C2C = 1'b1;
`else
  localparam bit C2C = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    read_miss, write_miss, search_found;
  logic [N*AW-1:0] bico;
  logic [2*N-1:0]  snoop_state;
  logic            mem_rdy;
  logic [N-1:0]    grant, search, wback, invalidate, datasel;
  logic [AW-1:0]   boci;
  logic            mem_re, mem_we, busy;

  int n_chk  = 0;
  int n_pass = 0;
  int ptr;

  always #5 clk = ~clk;

  snoop_bus_ctrl #(.NUM_CPU(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .read_miss(read_miss), .write_miss(write_miss),
    .bico(bico), .search_found(search_found), .snoop_state(snoop_state),
    .mem_rdy(mem_rdy), .grant(grant), .boci(boci), .search(search),
    .wback(wback), .invalidate(invalidate), .datasel(datasel),
    .mem_re(mem_re), .mem_we(mem_we), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] vec(input logic [N-1:0] g, s, wb, inv, ds,
                                      input logic re, we, bz);
    return 64'({g, s, wb, inv, ds, re, we, bz});
  endfunction

  function automatic logic [63:0] dut_vec();
    return vec(grant, search, wback, invalidate, datasel, mem_re, mem_we, busy);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    read_miss = '0; write_miss = '0; bico = '0;
    search_found = '0; snoop_state = '0; mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", dut_vec(), 64'd0);
    chk("reset_boci", 64'(boci), 64'd0);
    rst_n = 1'b1;
    ptr = N - 1;
  endtask

  // One transaction, starting in an IDLE cycle; every cycle is compared at the falling edge.
  task automatic run_txn(input string nm, input logic [N-1:0] rm, wm,
                         input logic [N*AW-1:0] addrs, input logic [N-1:0] fnd,
                         input logic [2*N-1:0] st, input int wbw, fw,
                         input bit drop, abort);
    int w, own, s;
    logic wr;
    logic [N-1:0] cand, shr, woh;
    @(negedge clk);
    chk({nm, "_idle"}, dut_vec(), 64'd0);
    read_miss = rm; write_miss = wm; bico = addrs;
    search_found = N'($urandom); snoop_state = 8'($urandom); mem_rdy = 1'($urandom);
    cand = rm | wm;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && cand[(ptr + k) % N]) w = (ptr + k) % N;
    wr  = wm[w];
    woh = oh(w);

    @(negedge clk);
    chk({nm, "_grant"}, dut_vec(), vec(woh, ~woh, '0, '0, '0, 0, 0, 1));
    chk({nm, "_boci"}, 64'(boci), 64'(addrs[w*AW +: AW]));
    if (drop) begin
      read_miss = '0; write_miss = '0; bico = rand_addrs();
    end
    mem_rdy = 1'($urandom);

    @(negedge clk);
    chk({nm, "_eval"}, dut_vec(), vec(woh, '0, '0, '0, '0, 0, 0, 1));
    chk({nm, "_boci_hold"}, 64'(boci), 64'(addrs[w*AW +: AW]));
    search_found = fnd; snoop_state = st; mem_rdy = 1'($urandom);
    own = -1; shr = '0;
    for (int i = 0; i < N; i++) begin
      s = int'(st[2*i +: 2]);
      if (i != w && fnd[i]) begin
        if (s == 1 || s == 2) shr[i] = 1'b1;
        if (s == 2 && own < 0) own = i;
      end
    end

    if (own >= 0) begin
      for (int j = 0; j <= wbw; j++) begin
        @(negedge clk);
        search_found = N'($urandom); snoop_state = 8'($urandom);
        chk({nm, "_wb"}, dut_vec(),
            vec(woh, '0, oh(own), '0, (C2C && !wr) ? woh : '0, 0, 1, 1));
        if (abort && j == 1) begin
          #2 rst_n = 1'b0;
          #1 chk({nm, "_async_rst"}, dut_vec(), 64'd0);
          chk({nm, "_async_rst_boci"}, 64'(boci), 64'd0);
          @(posedge clk);
          @(negedge clk);
          chk({nm, "_rst_hold"}, dut_vec(), 64'd0);
          read_miss = '0; write_miss = '0; mem_rdy = 1'b0;
          rst_n = 1'b1;
          ptr = N - 1;
          return;
        end
        mem_rdy = (j == wbw);
      end
    end

    if (wr) begin
      @(negedge clk);
      chk({nm, "_inval"}, dut_vec(), vec(woh, '0, '0, shr, '0, 0, 0, 1));
      mem_rdy = 1'($urandom);
    end else if (!(C2C && own >= 0)) begin
      for (int j = 0; j <= fw; j++) begin
        @(negedge clk);
        chk({nm, "_fill"}, dut_vec(), vec(woh, '0, '0, '0, woh, 1, 0, 1));
        mem_rdy = (j == fw);
      end
    end

    @(negedge clk);
    chk({nm, "_done"}, dut_vec(), vec('0, '0, '0, '0, '0, 0, 0, 1));
    mem_rdy = 1'($urandom);
    ptr = w;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*AW-1:0] a;
    logic [N-1:0] rm, wm;
    do_reset();
    repeat (2) begin
      @(negedge clk);
      chk("idle_noreq", dut_vec(), 64'd0);
    end

    a = rand_addrs(); a[0 +: AW] = 11'h0A5;
    run_txn("rd_fill", 4'b0001, 4'b0000, a, 4'b0000, 8'h00, 0, 2, 0, 0);

    do_reset();
    for (int k = 0; k < 5; k++)
      run_txn("rr_all", 4'b1111, 4'b0000, rand_addrs(), 4'b0000, 8'h00, 0, 0, 0, 0);

    a = rand_addrs(); a[2*AW +: AW] = 11'h3FF;
    run_txn("wr_inval", 4'b0000, 4'b0100, a, 4'b1001, 8'b01_00_00_01, 0, 0, 0, 0);
    run_txn("rd_owner", 4'b0010, 4'b0000, rand_addrs(), 4'b1000, 8'b10_00_00_00, 2, 1, 0, 0);
    run_txn("wr_owner", 4'b0000, 4'b0001, rand_addrs(), 4'b0110, 8'b00_10_01_00, 1, 0, 1, 0);

    do_reset();
    run_txn("rw_same", 4'b0001, 4'b0001, rand_addrs(), 4'b0000, 8'h00, 0, 0, 0, 0);
    run_txn("rst_in_wb", 4'b0010, 4'b0000, rand_addrs(), 4'b1000, 8'b10_00_00_00, 4, 0, 0, 1);
    run_txn("after_rst", 4'b1111, 4'b0000, rand_addrs(), 4'b0000, 8'h00, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      rm = N'($urandom);
      wm = ($urandom % 3 == 0) ? N'($urandom) : '0;
      if ((rm | wm) == '0) rm = oh(int'($urandom % N));
      run_txn("rand", rm, wm, rand_addrs(), N'($urandom), 8'($urandom),
              int'($urandom % 3), int'($urandom % 3), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
